sum_accumulator: RTL and testbench
==================================

# sum_accumulator

Registered accumulator downstream of the 4-bit ripple adder: it consumes the adder's 5-bit `sum` stream and totals a programmable number of samples into a saturating 8-bit result. Each sample enters through a valid/ready handshake and the total leaves through another. This makes it the first sequential stage after the combinational adder in the lab datapath, and it lets the bench and board checks read accumulated results instead of single sums.

## Interface
Parameters:
- `IN_W`, 5, width of incoming sum (adder output width)
- `ACC_W`, 8, accumulator/result width
- `CNT_W`, 4, width of sample-count fields

Ports:
- `clk`  input  1  single clock, all logic on rising edge
- `rst`  input  1  synchronous, active-high reset
- `in_valid`  input  1  `in_sum` carries a sample
- `in_ready`  output  1  block accepts a sample this cycle
- `in_sum`  input  IN_W  adder sum, unsigned
- `len`  input  CNT_W  samples per transaction, sampled with the first sample; 0 treated as 1
- `out_valid`  output  1  `acc_out`/`ovf`/`count_out` hold a finished result
- `out_ready`  input  1  consumer takes the result
- `acc_out`  output  ACC_W  accumulated total, unsigned, saturating
- `ovf`  output  1  saturation occurred during this transaction (sticky per transaction)
- `count_out`  output  CNT_W  samples accepted in this transaction

## Operation
- A sample transfer occurs when `in_valid && in_ready` at a rising edge. A result transfer occurs when `out_valid && out_ready`.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - `in_ready`=1, `out_valid`=0.
  - On a transfer: acc←`in_sum`, cnt←1, len_q←max(`len`,1), ovf←0.
  - Next state is DONE if len_q==1, otherwise ACCUM.
- ACCUM:
  - `in_ready`=1.
  - On a transfer: acc←sat(acc+`in_sum`), cnt←cnt+1, ovf←ovf | carry-out of the add.
  - When the incremented cnt equals len_q, go to DONE.
  - Cycles without a transfer hold all state.
- DONE:
  - `in_ready`=0, `out_valid`=1.
  - `acc_out`, `ovf` and `count_out` are stable and must not change until the result transfer.
  - On the result transfer go to IDLE. acc, cnt and ovf stay as they are until the next first sample overwrites them.
- Saturation rule:
  - Compute the sum at ACC_W+1 bits; `in_sum` is zero-extended.
  - If the MSB is set, acc←2^ACC_W−1 (255) and ovf←1.
  - Once saturated, acc remains 255 for the rest of the transaction.
- `len` is ignored after the first sample; changes mid-transaction have no effect.
- `in_sum` is only sampled on a transfer; X or garbage while `in_valid`=0 is harmless.

## Timing
- Reset (`rst`=1 at an edge):
  - state←IDLE, acc←0, cnt←0, ovf←0, len_q←0.
  - Outputs after reset: `out_valid`=0, `acc_out`=0, `ovf`=0, `count_out`=0, `in_ready`=1 from the first cycle after reset deasserts.
- Reset mid-transaction (ACCUM or DONE) discards the partial or pending result. No `out_valid` pulse follows.
- Latency:
  - `out_valid` rises on the edge that accepts the last sample, so it is visible the cycle after that sample's transfer.
  - Minimum transaction with len≤1: 1 input cycle, then `out_valid` high on the next cycle.
- Throughput: at most one sample per cycle. At least one bubble (DONE) separates transactions. `in_ready` is 0 while `out_valid`=1.
- `in_ready` and `out_valid` are decoded from registered state only, with no combinational path from `out_ready` or `in_valid`.
- If `out_ready` is held high in DONE, the return to IDLE takes one cycle. A new first sample is accepted in IDLE the cycle after that.

## Structure
- Package `sum_acc_pkg`:
  - state enum `acc_state_t` {IDLE, ACCUM, DONE}
  - width constants for IN_W, ACC_W, CNT_W
  - constant `ACC_MAX` = 2^ACC_W−1
- Sub-module `sat_add`: combinational ACC_W-bit saturating adder with inputs a[ACC_W], b[IN_W] and outputs y[ACC_W], sat. Kept separate so it can be checked on its own.
- Top level: FSM, count/len registers, result registers.

## Test plan
- len=3, samples 16, 29, 0 with `out_ready`=1 → `out_valid` one cycle after the third transfer; `acc_out`=45, `ovf`=0, `count_out`=3.
- len=15, fifteen samples of 30 (=15+15) → `acc_out`=255, `ovf`=1, `count_out`=15; saturation first occurs at sample 9 (cumulative 270).
- len=0, single sample 14 → treated as len=1; `acc_out`=14, `count_out`=1, `out_valid` on the next cycle.
- len=2, samples 6 and 5 with `in_valid` gaps of 3 cycles between them; `out_ready`=0 for 5 cycles in DONE → `acc_out`=11 held stable and `in_ready`=0 throughout; IDLE one cycle after `out_ready` rises.
- len=4, `rst` asserted after 2 samples (7, 9) → next cycle all outputs 0 and `in_ready`=1; a fresh len=1 transaction with sample 3 yields `acc_out`=3, `ovf`=0.
- Back-to-back transactions: len=1 with sample 31, then len=1 with sample 1 → two results, 31 then 1, with no carry-over.

Source files
------------

// File: rtl/sum_acc_pkg.sv
// Shared widths, saturation limit and FSM state type for the sum accumulator.
package sum_acc_pkg;

  localparam int unsigned IN_W  = 5;
  localparam int unsigned ACC_W = 8;
  localparam int unsigned CNT_W = 4;

  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_t;

endpackage

// File: rtl/sat_add.sv
// Combinational saturating adder: ACC_W-bit running total plus a zero-extended IN_W-bit sample.
module sat_add #(
  parameter int unsigned IN_W  = sum_acc_pkg::IN_W,
  parameter int unsigned ACC_W = sum_acc_pkg::ACC_W
) (
  input  logic [ACC_W-1:0] a,
  input  logic [IN_W-1:0]  b,
  output logic [ACC_W-1:0] y,
  output logic             sat
);

  logic [ACC_W:0] sum_full;

  always_comb begin
    sum_full = {1'b0, a} + (ACC_W+1)'(b);
    sat      = sum_full[ACC_W];
    // The carry-out clamps to all-ones, so a saturated total stays at the maximum.
    y        = sat ? '1 : sum_full[ACC_W-1:0];
  end

endmodule

// File: rtl/sum_accumulator.sv
// Totals a programmable number of adder sums into a saturating result,
// with valid/ready handshakes on both the sample input and the result output.
module sum_accumulator #(
  parameter int unsigned IN_W  = sum_acc_pkg::IN_W,
  parameter int unsigned ACC_W = sum_acc_pkg::ACC_W,
  parameter int unsigned CNT_W = sum_acc_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_sum,
  input  logic [CNT_W-1:0] len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf,
  output logic [CNT_W-1:0] count_out
);

  import sum_acc_pkg::*;

  acc_state_t state_q, state_d;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;

  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] len_eff;
  logic [ACC_W-1:0] add_y;
  logic             add_sat;
  logic             in_fire;

  sat_add #(
    .IN_W  (IN_W),
    .ACC_W (ACC_W)
  ) u_sat_add (
    .a   (acc_q),
    .b   (in_sum),
    .y   (add_y),
    .sat (add_sat)
  );

  always_comb begin
    cnt_inc = cnt_q + CNT_W'(1);
    len_eff = (len == '0) ? CNT_W'(1) : len;
    in_fire = in_valid && in_ready;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (in_fire) begin
          state_d = (len_eff == CNT_W'(1)) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (in_fire && (cnt_inc == len_q)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs depend on registered state only
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE:    in_ready  = 1'b1;
      ACCUM:   in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    len_d = len_q;
    ovf_d = ovf_q;
    if (in_fire) begin
      if (state_q == IDLE) begin
        acc_d = ACC_W'(in_sum);
        cnt_d = CNT_W'(1);
        len_d = len_eff;
        ovf_d = 1'b0;
      end else if (state_q == ACCUM) begin
        acc_d = add_y;
        cnt_d = cnt_inc;
        ovf_d = ovf_q | add_sat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      ovf_q <= ovf_d;
    end
  end

  always_comb begin
    acc_out   = acc_q;
    ovf       = ovf_q;
    count_out = cnt_q;
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed self-checking bench for sum_accumulator with hand-computed expectations.
module tb_sum_accumulator;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_sum;
  logic [3:0] len;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] acc_out;
  logic       ovf;
  logic [3:0] count_out;

  int passed;
  int failed;
  int total;

  sum_accumulator #(
    .IN_W  (5),
    .ACC_W (8),
    .CNT_W (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .len       (len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_out   (acc_out),
    .ovf       (ovf),
    .count_out (count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic result(input string tag, input int a, input int o, input int c);
    check({tag, "_valid"}, 32'(out_valid), 1);
    check({tag, "_rdy"},   32'(in_ready),  0);
    check({tag, "_acc"},   32'(acc_out),   32'(a));
    check({tag, "_ovf"},   32'(ovf),       32'(o));
    check({tag, "_cnt"},   32'(count_out), 32'(c));
  endtask

  // Waits (bounded) for in_ready, then transfers one sample and scrambles the idle inputs.
  task automatic send(input logic [4:0] s, input logic [3:0] l);
    int unsigned n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("send_ready", 32'(in_ready), 1);
    in_valid = 1'b1;
    in_sum   = s;
    len      = l;
    tick();
    in_valid = 1'b0;
    in_sum   = 5'($urandom);
    len      = 4'($urandom);
  endtask

  initial begin
    int exp_acc;
    passed    = 0;
    failed    = 0;
    total     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sum    = '0;
    len       = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_valid", 32'(out_valid), 0);
    check("rst_rdy",   32'(in_ready),  1);
    check("rst_acc",   32'(acc_out),   0);
    check("rst_ovf",   32'(ovf),       0);
    check("rst_cnt",   32'(count_out), 0);

    // len=3: 16+29+0
    out_ready = 1'b1;
    send(5'd16, 4'd3);
    check("t1_mid_valid", 32'(out_valid), 0);
    send(5'd29, 4'd3);
    send(5'd0, 4'd3);
    result("t1", 45, 0, 3);
    tick();
    check("t1_idle_valid", 32'(out_valid), 0);
    check("t1_idle_rdy",   32'(in_ready),  1);

    // len=15: fifteen samples of 30, saturating at sample 9
    out_ready = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      send(5'd30, 4'd15);
      exp_acc = (30 * i > 255) ? 255 : 30 * i;
      if (i < 15) begin
        check("t2_acc", 32'(acc_out),   32'(exp_acc));
        check("t2_ovf", 32'(ovf),       (i >= 9) ? 1 : 0);
        check("t2_cnt", 32'(count_out), 32'(i));
      end
    end
    result("t2", 255, 1, 15);
    out_ready = 1'b1;
    tick();
    check("t2_idle_valid", 32'(out_valid), 0);

    // len=0 behaves as len=1
    send(5'd14, 4'd0);
    result("t3", 14, 0, 1);
    tick();
    out_ready = 1'b0;

    // len=2 with input gaps, result held while out_ready is low
    send(5'd6, 4'd2);
    for (int g = 0; g < 3; g++) begin
      tick();
      check("t4_gap_valid", 32'(out_valid), 0);
      check("t4_gap_acc",   32'(acc_out),   6);
    end
    send(5'd5, 4'd2);
    for (int h = 0; h < 5; h++) begin
      result("t4_hold", 11, 0, 2);
      tick();
    end
    result("t4_hold", 11, 0, 2);
    out_ready = 1'b1;
    tick();
    check("t4_idle_valid", 32'(out_valid), 0);
    check("t4_idle_rdy",   32'(in_ready),  1);

    // reset mid-transaction
    send(5'd7, 4'd4);
    send(5'd9, 4'd4);
    check("t5_part_acc", 32'(acc_out), 16);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_rst_valid", 32'(out_valid), 0);
    check("t5_rst_rdy",   32'(in_ready),  1);
    check("t5_rst_acc",   32'(acc_out),   0);
    check("t5_rst_ovf",   32'(ovf),       0);
    check("t5_rst_cnt",   32'(count_out), 0);
    tick();
    check("t5_no_valid", 32'(out_valid), 0);
    send(5'd3, 4'd1);
    result("t5", 3, 0, 1);
    tick();

    // back-to-back single-sample transactions
    send(5'd31, 4'd1);
    result("t6a", 31, 0, 1);
    tick();
    check("t6_idle_rdy", 32'(in_ready), 1);
    send(5'd1, 4'd1);
    result("t6b", 1, 0, 1);
    tick();
    check("t6_end_valid", 32'(out_valid), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
